// File: rtl/iob_nco_clkgen_pkg.sv
// Shared definitions for the NCO clock generator.
//   - CSR word addresses
//   - PERIOD_W: width of the integer and fractional period registers
//   - nco_state_e: datapath sequencing state, exported on the debug port
//   - apply_wstrb: byte-strobe merge used by the register file
package iob_nco_clkgen_pkg;

    localparam int PERIOD_W = 32;

    localparam logic [31:0] SOFT_RESET_ADDR  = 32'd0;
    localparam logic [31:0] ENABLE_ADDR      = 32'd1;
    localparam logic [31:0] PERIOD_INT_ADDR  = 32'd2;
    localparam logic [31:0] PERIOD_FRAC_ADDR = 32'd3;

    // ST_ARMED: halted; the next enabled cycle begins a fresh period.
    // ST_RUN  : counting through a period of length len.
    // ST_HOLD : PERIOD_INT < 2; output parked low, every cycle is a period start.
    typedef enum logic [1:0] {
        ST_ARMED = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2
    } nco_state_e;

    function automatic logic [PERIOD_W-1:0] apply_wstrb(
        input logic [PERIOD_W-1:0]   old_v,
        input logic [PERIOD_W-1:0]   new_v,
        input logic [PERIOD_W/8-1:0] strb
    );
        logic [PERIOD_W-1:0] res;
        res = old_v;
        for (int b = 0; b < PERIOD_W/8; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/iob_nco_clkgen_if.sv
// IOb native bus between a master and the NCO CSR slave.
// Handshake: a request is transferred on every clock edge where valid is 1
// (ready is always 1 on this slave); wstrb != 0 marks a write, wstrb == 0 a
// read. Read data comes back one cycle later, qualified by a one-cycle
// rvalid pulse; rdata is 0 whenever rvalid is 0. rready is carried but the
// slave never stalls on it.
interface iob_nco_clkgen_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) ();
    logic                valid;
    logic [ADDR_W-3:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   rdata;
    logic                ready;
    logic                rvalid;
    logic                rready;

    modport master (
        output valid, addr, wdata, wstrb, rready,
        input  rdata, ready, rvalid
    );

    modport slave (
        input  valid, addr, wdata, wstrb, rready,
        output rdata, ready, rvalid
    );
endinterface

// File: rtl/iob_nco_clkgen_csrs.sv
// CSR register file and IOb handshake for the NCO clock generator.
// Ports:
//   clk_i, arst_n_i  clock, asynchronous active-low reset
//   cke_i            clock enable; when 0 every register holds
//   iob              IOb slave (word addressed)
//   soft_reset_o, enable_o, period_int_o, period_frac_o  register values
module iob_nco_clkgen_csrs
    import iob_nco_clkgen_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    iob_nco_clkgen_if.slave     iob,
    output logic                soft_reset_o,
    output logic                enable_o,
    output logic [PERIOD_W-1:0] period_int_o,
    output logic [PERIOD_W-1:0] period_frac_o
);

    localparam int AW = ADDR_W - 2;

    logic                soft_reset_q;
    logic                enable_q;
    logic [PERIOD_W-1:0] period_int_q;
    logic [PERIOD_W-1:0] period_frac_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [31:0]         word_idx;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_W-1:0]   rd_mux;

    always_comb begin
        word_idx = {{(32-AW){1'b0}}, iob.addr};
        wr_en    = iob.valid & (|iob.wstrb);
        rd_en    = iob.valid & ~(|iob.wstrb);
        rd_mux   = '0;
        case (word_idx)
            SOFT_RESET_ADDR:  rd_mux = {{(DATA_W-1){1'b0}}, soft_reset_q};
            ENABLE_ADDR:      rd_mux = {{(DATA_W-1){1'b0}}, enable_q};
            PERIOD_INT_ADDR:  rd_mux = period_int_q;
            PERIOD_FRAC_ADDR: rd_mux = period_frac_q;
            default:          rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            soft_reset_q  <= 1'b0;
            enable_q      <= 1'b0;
            period_int_q  <= '0;
            period_frac_q <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
        end else if (cke_i) begin
            if (wr_en) begin
                case (word_idx)
                    // Single-bit registers live in byte lane 0.
                    SOFT_RESET_ADDR:  if (iob.wstrb[0]) soft_reset_q <= iob.wdata[0];
                    ENABLE_ADDR:      if (iob.wstrb[0]) enable_q <= iob.wdata[0];
                    PERIOD_INT_ADDR:  period_int_q  <= apply_wstrb(period_int_q, iob.wdata, iob.wstrb);
                    PERIOD_FRAC_ADDR: period_frac_q <= apply_wstrb(period_frac_q, iob.wdata, iob.wstrb);
                    default: ;
                endcase
            end
            rvalid_q <= rd_en;
            rdata_q  <= rd_en ? rd_mux : '0;
        end
    end

    assign iob.ready     = 1'b1;
    assign iob.rvalid    = rvalid_q;
    assign iob.rdata     = rdata_q;
    assign soft_reset_o  = soft_reset_q;
    assign enable_o      = enable_q;
    assign period_int_o  = period_int_q;
    assign period_frac_o = period_frac_q;

endmodule

// File: rtl/iob_nco_clkgen.sv
// Numerically controlled oscillator: produces clk_out_o with an average
// period of PERIOD_INT + PERIOD_FRAC/2^32 clk_i cycles.
// Ports:
//   clk_i        system clock
//   arst_n_i     asynchronous active-low reset
//   cke_i        clock enable; 0 freezes all state
//   iob          IOb CSR slave (see iob_nco_clkgen_if)
//   clk_out_o    generated clock (registered)
//   dbg_state_o  datapath sequencing state
module iob_nco_clkgen
    import iob_nco_clkgen_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic            clk_i,
    input  logic            arst_n_i,
    input  logic            cke_i,
    iob_nco_clkgen_if.slave iob,
    output logic            clk_out_o,
    output nco_state_e      dbg_state_o
);

    logic                soft_reset;
    logic                enable;
    logic [PERIOD_W-1:0] period_int;
    logic [PERIOD_W-1:0] period_frac;

    iob_nco_clkgen_csrs #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_csrs (
        .clk_i         (clk_i),
        .arst_n_i      (arst_n_i),
        .cke_i         (cke_i),
        .iob           (iob),
        .soft_reset_o  (soft_reset),
        .enable_o      (enable),
        .period_int_o  (period_int),
        .period_frac_o (period_frac)
    );

    nco_state_e          state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] facc_q, facc_d;
    logic [PERIOD_W:0]   len_q, len_d;
    logic                clk_q, clk_d;

    logic                halt;
    logic                short_period;
    logic                at_end;
    logic                start;
    logic [PERIOD_W:0]   facc_sum;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_ARMED;
            cnt_q   <= '0;
            facc_q  <= '0;
            len_q   <= '0;
            clk_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            facc_q  <= facc_d;
            len_q   <= len_d;
            clk_q   <= clk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        facc_d  = facc_q;
        len_d   = len_q;
        clk_d   = clk_q;

        halt         = soft_reset | ~enable;
        short_period = (period_int < 32'd2);
        at_end       = ({1'b0, cnt_q} == (len_q - 33'd1));
        // Outside ST_RUN every enabled cycle begins a period, so leaving
        // ST_HOLD or ST_ARMED always latches fresh CSR values.
        start        = (state_q != ST_RUN) | at_end | short_period;
        facc_sum     = {1'b0, facc_q} + {1'b0, period_frac};

        if (halt) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
            facc_d  = '0;
            len_d   = '0;
            clk_d   = 1'b0;
        end else begin
            state_d = short_period ? ST_HOLD : ST_RUN;
            if (start) begin
                // CSRs are sampled only here, so a period never changes length mid-flight.
                facc_d = facc_sum[PERIOD_W-1:0];
                len_d  = {1'b0, period_int} + {{PERIOD_W{1'b0}}, facc_sum[PERIOD_W]};
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            // Computed from the next count so the registered output lines up
            // with cnt: high for floor(len/2) cycles, odd remainder low.
            clk_d = ~short_period & ({1'b0, cnt_d} < (len_d >> 1));
        end
    end

    assign clk_out_o   = clk_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iob_nco_clkgen.sv
module tb_iob_nco_clkgen;
    import iob_nco_clkgen_pkg::*;

    localparam int W = 33;

    logic       clk_i    = 1'b0;
    logic       arst_n_i = 1'b0;
    logic       cke_i    = 1'b1;
    logic       clk_out_o;
    nco_state_e dbg_state;

    iob_nco_clkgen_if #(.ADDR_W(4), .DATA_W(32)) iob ();

    iob_nco_clkgen #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .cke_i       (cke_i),
        .iob         (iob),
        .clk_out_o   (clk_out_o),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint unsigned got, input longint unsigned want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    endtask

    // ---------------- output monitor ----------------
    int unsigned    cyc = 0;
    int unsigned    last_rise = 0;
    int unsigned    last_fall = 0;
    bit             have_rise = 1'b0;
    logic           prev_out  = 1'b0;
    logic [W-1:0]   meas_p[$];
    logic [W-1:0]   meas_h[$];

    always @(negedge clk_i) begin
        cyc++;
        if (clk_out_o === 1'b1 && prev_out === 1'b0) begin
            if (have_rise) begin
                meas_p.push_back(W'(cyc - last_rise));
                meas_h.push_back(W'(last_fall - last_rise));
            end
            have_rise = 1'b1;
            last_rise = cyc;
        end
        if (clk_out_o === 1'b0 && prev_out === 1'b1) last_fall = cyc;
        prev_out = clk_out_o;
    end

    task automatic mon_reset();
        @(posedge clk_i); #1;
        have_rise = 1'b0;
        meas_p.delete();
        meas_h.delete();
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_h_q[$];

    // Length of the k-th period (k >= 1) starting from facc = 0: the integer
    // part plus one whenever k*frac crosses another multiple of 2^32.
    function automatic logic [W-1:0] model_len(input int k, input logic [31:0] int_v, input logic [31:0] frac_v);
        longint unsigned a, b;
        a = (longint'(k) * longint'(frac_v)) >> 32;
        b = (longint'(k - 1) * longint'(frac_v)) >> 32;
        return W'(longint'(int_v) + a - b);
    endfunction

    // ---------------- bus drivers ----------------
    task automatic csr_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk_i);
        iob.valid = 1'b1;
        iob.addr  = addr[1:0];
        iob.wdata = data;
        iob.wstrb = strb;
        @(negedge clk_i);
        iob.valid = 1'b0;
        iob.wstrb = 4'h0;
    endtask

    task automatic csr_read(input string name, input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk_i);
        iob.valid = 1'b1;
        iob.addr  = addr[1:0];
        iob.wstrb = 4'h0;
        @(negedge clk_i);
        iob.valid = 1'b0;
        check({name, " rvalid"}, iob.rvalid, 1);
        data = iob.rdata;
        @(negedge clk_i);
        check({name, " rvalid_drop"}, iob.rvalid, 0);
        check({name, " rdata_idle"}, iob.rdata, 0);
    endtask

    task automatic wait_periods(input string name, input int n);
        int c = 0;
        while (meas_p.size() < n && c < n * 64 + 500) begin
            @(negedge clk_i);
            c++;
        end
        check({name, " period_count"}, (meas_p.size() >= n), 1);
    endtask

    task automatic wait_rise(input string name);
        int c = 0;
        while (!have_rise && c < 200) begin
            @(negedge clk_i); #1;
            c++;
        end
        check({name, " rise_seen"}, have_rise, 1);
    endtask

    task automatic compare_periods(input string name, output longint unsigned total);
        logic [W-1:0] got_p, got_h;
        total = 0;
        while (exp_q.size() > 0) begin
            got_p = (meas_p.size() > 0) ? meas_p.pop_front() : '0;
            got_h = (meas_h.size() > 0) ? meas_h.pop_front() : '0;
            check({name, " period"}, got_p, exp_q.pop_front());
            check({name, " high"}, got_h, exp_h_q.pop_front());
            total += got_p;
        end
    endtask

    task automatic run_case(input string name, input logic [31:0] int_v, input logic [31:0] frac_v,
                            input int n, output longint unsigned total);
        csr_write(ENABLE_ADDR, 32'd0, 4'hF);
        csr_write(PERIOD_INT_ADDR, int_v, 4'hF);
        csr_write(PERIOD_FRAC_ADDR, frac_v, 4'hF);
        mon_reset();
        for (int k = 1; k <= n; k++) begin
            exp_q.push_back(model_len(k, int_v, frac_v));
            exp_h_q.push_back(model_len(k, int_v, frac_v) >> 1);
        end
        csr_write(ENABLE_ADDR, 32'd1, 4'hF);
        wait_periods(name, n);
        compare_periods(name, total);
    endtask

    // Halt the NCO while the output is high, then resume and expect the
    // fractional sequence to restart from facc = 0.
    task automatic halt_while_high(input string name, input logic [31:0] addr,
                                   input logic [31:0] halt_v, input logic [31:0] resume_v);
        int highs;
        longint unsigned total;
        mon_reset();
        wait_rise(name);
        csr_write(addr, halt_v, 4'hF);
        check({name, " still_high"}, clk_out_o, 1);
        @(negedge clk_i);
        check({name, " low_next"}, clk_out_o, 0);
        highs = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (clk_out_o !== 1'b0) highs++;
        end
        check({name, " stays_low"}, highs, 0);
        mon_reset();
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(model_len(k, 32'h12, 32'h8000_0000));
            exp_h_q.push_back(model_len(k, 32'h12, 32'h8000_0000) >> 1);
        end
        csr_write(addr, resume_v, 4'hF);
        wait_periods(name, 3);
        compare_periods(name, total);
    endtask

    // ---------------- CSR vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } csr_vec_t;

    csr_vec_t csr_tbl[8];

    // ---------------- main ----------------
    initial begin
        logic [31:0]     rd;
        longint unsigned total;
        int              highs;

        iob.valid  = 1'b0;
        iob.addr   = '0;
        iob.wdata  = '0;
        iob.wstrb  = '0;
        iob.rready = 1'b1;

        csr_tbl[0] = '{PERIOD_INT_ADDR,  32'h0000_0012, 4'hF, 32'h0000_0012};
        csr_tbl[1] = '{PERIOD_FRAC_ADDR, 32'h8000_0000, 4'hF, 32'h8000_0000};
        csr_tbl[2] = '{PERIOD_INT_ADDR,  32'hFFFF_FFFF, 4'h1, 32'h0000_00FF};
        csr_tbl[3] = '{PERIOD_FRAC_ADDR, 32'h1234_5678, 4'hC, 32'h1234_0000};
        csr_tbl[4] = '{SOFT_RESET_ADDR,  32'hFFFF_FFFF, 4'hF, 32'h0000_0001};
        csr_tbl[5] = '{SOFT_RESET_ADDR,  32'hFFFF_FFFE, 4'h1, 32'h0000_0000};
        csr_tbl[6] = '{ENABLE_ADDR,      32'h0000_0003, 4'h2, 32'h0000_0000};
        csr_tbl[7] = '{PERIOD_INT_ADDR,  32'hAABB_CCDD, 4'h6, 32'h00BB_CCFF};

        // Reset
        repeat (100) @(negedge clk_i);
        check("reset clk_out", clk_out_o, 0);
        check("reset rvalid", iob.rvalid, 0);
        arst_n_i = 1'b1;
        @(negedge clk_i);
        check("post_reset clk_out", clk_out_o, 0);
        check("post_reset rdata", iob.rdata, 0);
        check("post_reset state", dbg_state, ST_ARMED);
        check("ready", iob.ready, 1);
        for (int a = 0; a < 4; a++) begin
            csr_read("reset_csr", 32'(a), rd);
            check("reset_csr value", rd, 0);
        end

        // CSR access table
        foreach (csr_tbl[i]) begin
            csr_write(csr_tbl[i].addr, csr_tbl[i].wdata, csr_tbl[i].wstrb);
            csr_read("csr_tbl", csr_tbl[i].addr, rd);
            check("csr_tbl value", rd, csr_tbl[i].exp_rdata);
        end

        // Fractional period 18.5
        csr_write(SOFT_RESET_ADDR, 32'd1, 4'hF);
        csr_write(SOFT_RESET_ADDR, 32'd0, 4'hF);
        run_case("frac", 32'h12, 32'h8000_0000, 100, total);
        check("frac total_100", total, 1850);

        // Integer periods
        run_case("int4", 32'd4, 32'd0, 6, total);
        run_case("int5", 32'd5, 32'd0, 6, total);

        // Dynamic change 10 -> 6 mid-period
        csr_write(ENABLE_ADDR, 32'd0, 4'hF);
        csr_write(PERIOD_INT_ADDR, 32'd10, 4'hF);
        csr_write(PERIOD_FRAC_ADDR, 32'd0, 4'hF);
        mon_reset();
        csr_write(ENABLE_ADDR, 32'd1, 4'hF);
        wait_rise("dyn");
        repeat (2) @(negedge clk_i);
        csr_write(PERIOD_INT_ADDR, 32'd6, 4'hF);
        exp_q.push_back(10); exp_h_q.push_back(5);
        exp_q.push_back(6);  exp_h_q.push_back(3);
        exp_q.push_back(6);  exp_h_q.push_back(3);
        wait_periods("dyn", 3);
        compare_periods("dyn", total);

        // Disable and soft reset while high
        run_case("pre_halt", 32'h12, 32'h8000_0000, 3, total);
        halt_while_high("disable", ENABLE_ADDR, 32'd0, 32'd1);
        halt_while_high("soft_rst", SOFT_RESET_ADDR, 32'd1, 32'd0);

        // PERIOD_INT < 2 parks the output, then recovers
        csr_write(ENABLE_ADDR, 32'd0, 4'hF);
        csr_write(PERIOD_INT_ADDR, 32'd1, 4'hF);
        csr_write(PERIOD_FRAC_ADDR, 32'h4000_0000, 4'hF);
        csr_write(ENABLE_ADDR, 32'd1, 4'hF);
        highs = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (clk_out_o !== 1'b0) highs++;
        end
        check("short held_low", highs, 0);
        csr_write(PERIOD_FRAC_ADDR, 32'd0, 4'hF);
        mon_reset();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(4);
            exp_h_q.push_back(2);
        end
        csr_write(PERIOD_INT_ADDR, 32'd4, 4'hF);
        wait_periods("short_recover", 3);
        compare_periods("short_recover", total);

        // Clock enable freezes datapath and CSRs
        csr_write(ENABLE_ADDR, 32'd0, 4'hF);
        csr_write(PERIOD_INT_ADDR, 32'd8, 4'hF);
        mon_reset();
        csr_write(ENABLE_ADDR, 32'd1, 4'hF);
        wait_rise("cke");
        repeat (2) @(negedge clk_i);
        cke_i = 1'b0;
        csr_write(PERIOD_INT_ADDR, 32'd3, 4'hF);
        repeat (18) @(negedge clk_i);
        cke_i = 1'b1;
        exp_q.push_back(28); exp_h_q.push_back(24);
        exp_q.push_back(8);  exp_h_q.push_back(4);
        wait_periods("cke", 2);
        compare_periods("cke", total);
        csr_read("cke_int", PERIOD_INT_ADDR, rd);
        check("cke_int value", rd, 8);

        // Randomized periods against the arithmetic model
        for (int r = 0; r < 6; r++) begin
            run_case("rand", 32'($urandom_range(2, 40)), $urandom(), 10, total);
        end

        // Asynchronous reset mid-period
        run_case("pre_arst", 32'h12, 32'h8000_0000, 1, total);
        mon_reset();
        wait_rise("arst");
        #2;
        arst_n_i = 1'b0;
        #1;
        check("arst clk_out", clk_out_o, 0);
        check("arst rvalid", iob.rvalid, 0);
        repeat (5) @(negedge clk_i);
        arst_n_i = 1'b1;
        csr_read("arst_enable", ENABLE_ADDR, rd);
        check("arst_enable value", rd, 0);
        csr_read("arst_int", PERIOD_INT_ADDR, rd);
        check("arst_int value", rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iob_nco_clkgen.md
Name: iob_nco_clkgen

Overview:
- Numerically controlled oscillator with an IOb-native CSR slave interface.
- Generates a square-wave clock clk_out_o whose period is programmed in clk_i cycles as a 32.32 fixed-point value.
- The average period may be fractional.
- Peripheral used by the SoC to synthesise auxiliary clocks from the system clock.

Parameters:
- DATA_W, 32: CSR data width (fixed at 32).
- ADDR_W, 4: CSR byte-address width; the port carries word address bits [ADDR_W-1:2].

Ports:
- clk_i  in  1  system clock, rising edge.
- arst_n_i  in  1  asynchronous reset, active-low.
- cke_i  in  1  clock enable; when 0 all state holds.
- iob_valid_i  in  1  request valid.
- iob_addr_i  in  ADDR_W-2  word address.
- iob_wdata_i  in  DATA_W  write data.
- iob_wstrb_i  in  DATA_W/8  byte strobes; nonzero means write, zero means read.
- iob_rdata_o  out  DATA_W  read data.
- iob_ready_o  out  1  request accepted.
- iob_rvalid_o  out  1  read data valid.
- iob_rready_i  in  1  read-data ready; ignored by this block.
- clk_out_o  out  1  generated clock.

Behaviour:
- Reset (arst_n_i=0): all CSRs 0, counters and accumulator 0, clk_out_o=0, iob_rvalid_o=0, iob_rdata_o=0.
- iob_ready_o is constant 1; every request is accepted in the cycle it is presented.
- CSR map (word index : name : width, access):
  - 0 : SOFT_RESET : 1 bit, RW
  - 1 : ENABLE : 1 bit, RW
  - 2 : PERIOD_INT : 32 bits, RW
  - 3 : PERIOD_FRAC : 32 bits, RW
- Write: valid & |wstrb updates the addressed register at the next clk_i edge. Byte strobes are honoured; unused bits are ignored.
- Read: valid & wstrb==0 gives iob_rvalid_o=1 for exactly one cycle on the following cycle. iob_rdata_o carries the register value, zero-extended. Unmapped words read 0. iob_rdata_o returns to 0 when rvalid is low.
- Datapath state:
  - cnt[31:0]: cycle counter.
  - facc[31:0]: fractional accumulator.
  - len[32:0]: current period length.
  - clk_out register.
- SOFT_RESET=1 or ENABLE=0: cnt=0, facc=0, clk_out_o=0, and a new period is armed. CSRs are unaffected.
- Period start (first enabled cycle, or cnt==len-1):
  - {carry, facc} <= facc + PERIOD_FRAC.
  - len <= PERIOD_INT + carry, using the register values sampled at that instant.
  - cnt <= 0.
  - CSR changes take effect only at the next period start; there is no glitch mid-period.
- Otherwise cnt <= cnt+1.
- clk_out_o is registered:
  - High while cnt < len>>1, low for the remainder.
  - Odd lengths spend the extra cycle low.
- PERIOD_INT < 2 while enabled: clk_out_o held 0, cnt held 0, facc still accumulates per cycle.
- Example: PERIOD_INT=18, PERIOD_FRAC=0x80000000 from facc=0 gives alternating lengths 18, 19, 18, 19… (average 18.5).
- cke_i=0 freezes all sequential state, including the CSRs.
- Reset mid-period returns to the reset state immediately (asynchronously).

Decomposition:
- Shared package iob_nco_clkgen_pkg holds:
  - CSR word addresses (SOFT_RESET_ADDR=0, ENABLE_ADDR=1, PERIOD_INT_ADDR=2, PERIOD_FRAC_ADDR=3).
  - PERIOD_W=32.
- Sub-module iob_nco_clkgen_csrs: register file plus IOb handshake.
- Top level holds the NCO datapath.

Test Plan:
- Reset: assert arst_n_i low 100 cycles, then release → clk_out_o=0, rvalid=0, all CSRs read 0.
- CSR access: write PERIOD_INT=0x12, PERIOD_FRAC=0x80000000, then read back → rvalid one cycle after each read, data 0x12 and 0x80000000; write wstrb=0x1 to PERIOD_INT with data 0xFFFFFFFF → reads 0x000000FF.
- Fractional period:
  - Stimulus: SOFT_RESET 1→0, then INT=0x12, FRAC=0x80000000, ENABLE=1.
  - clk_out_o periods alternate 18/19 cycles.
  - High time 9 cycles in each period.
  - Over 100 periods the total is 1850 cycles.
- Integer period: INT=4, FRAC=0 → 2 high / 2 low repeatedly; INT=5 → 2 high / 3 low.
- Dynamic change: change INT 10→6 mid-period → current period completes at 10 cycles, next is 6; no runt pulse.
- Disable/soft reset: ENABLE=0 or SOFT_RESET=1 while clk_out_o is high → clk_out_o low the next cycle; re-enable restarts with facc=0 (first fractional period 18).
